// File: rtl/fc_argmax.sv
// Argmax over a packed vector of signed FC scores: capture, sequential scan, hold result.
// Optional macro FC_ARGMAX_RELU_EN clamps each lane to max(lane, 0) at capture.
module fc_argmax #(
  parameter int BITWIDTH    = 8,
  parameter int OUTPUT_SIZE = 5,
  localparam int IDX_W      = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1,
  localparam int SW         = 2 * BITWIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SW*OUTPUT_SIZE-1:0] result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_index,
  output logic [SW-1:0]             out_value,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(OUTPUT_SIZE - 1);

  state_t                state_q, state_d;
  logic signed [SW-1:0]  vec_q [OUTPUT_SIZE];
  logic signed [SW-1:0]  vec_d [OUTPUT_SIZE];
  logic signed [SW-1:0]  max_q, max_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic signed [SW-1:0]  val_q, val_d;
  logic [IDX_W-1:0]      oidx_q, oidx_d;
  logic signed [SW-1:0]  lane_w;
  logic signed [SW-1:0]  cand_max;
  logic [IDX_W-1:0]      cand_idx;

`ifdef FC_ARGMAX_RELU_EN
  function automatic logic signed [SW-1:0] capture(input logic signed [SW-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction
`else
  function automatic logic signed [SW-1:0] capture(input logic signed [SW-1:0] x);
    return x;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    max_d   = max_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    val_d   = val_q;
    oidx_d  = oidx_q;

    // Strict greater-than keeps the lowest index on ties.
    lane_w   = vec_q[ptr_q];
    cand_max = max_q;
    cand_idx = idx_q;
    if (lane_w > max_q) begin
      cand_max = lane_w;
      cand_idx = ptr_q;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < OUTPUT_SIZE; i++) begin
            vec_d[i] = capture(result[(i+1)*SW-1 -: SW]);
          end
          max_d = vec_d[0];
          idx_d = '0;
          ptr_d = IDX_W'(1);
          if (OUTPUT_SIZE == 1) begin
            state_d = DONE;
            val_d   = vec_d[0];
            oidx_d  = '0;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        max_d = cand_max;
        idx_d = cand_idx;
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == LAST) begin
          state_d = DONE;
          val_d   = cand_max;
          oidx_d  = cand_idx;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < OUTPUT_SIZE; i++) vec_q[i] <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      val_q   <= '0;
      oidx_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      val_q   <= val_d;
      oidx_q  <= oidx_d;
    end
  end

  // Handshakes are forced low while reset is asserted.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE) && !rst;
  assign busy      = (state_q != IDLE) && !rst;
  assign out_index = oidx_q;
  assign out_value = val_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Randomized self-checking bench for fc_argmax against a plain argmax reference model.
module tb_fc_argmax;
  localparam int BW = 8;
  localparam int N  = 5;
  localparam int SW = 2 * BW;
  localparam int IW = 3;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [SW*N-1:0] result;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_index;
  logic [SW-1:0]   out_value;
  logic            busy;

  int pass_cnt = 0;
  int total    = 0;

  typedef int lanes_t [N];

  fc_argmax #(.BITWIDTH(BW), .OUTPUT_SIZE(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_value(out_value), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int clampf(input int x);
`ifdef FC_ARGMAX_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  // First index holding the largest (optionally clamped) score.
  function automatic void model(input lanes_t l, output int idx, output int val);
    idx = 0;
    val = clampf(l[0]);
    for (int i = 1; i < N; i++) begin
      if (clampf(l[i]) > val) begin
        val = clampf(l[i]);
        idx = i;
      end
    end
  endfunction

  function automatic logic [SW*N-1:0] pack(input lanes_t l);
    logic [SW*N-1:0] p;
    for (int i = 0; i < N; i++) p[i*SW +: SW] = SW'(l[i]);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_lanes(output lanes_t l, input bit narrow);
    for (int i = 0; i < N; i++) begin
      if (narrow) l[i] = int'($urandom_range(0, 7)) - 4;
      else        l[i] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  // Present a vector for one edge, scramble the bus, wait (bounded) for out_valid.
  task automatic run_one(input lanes_t l, output int lat);
    result   = pack(l);
    in_valid = 1;
    step();
    in_valid = 0;
    result   = (SW*N)'({$urandom(), $urandom(), $urandom()});
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  task automatic test_reset();
    lanes_t l = '{1, 2, 3, 4, 5};
    rst = 1;
    in_valid = 1;
    result = pack(l);
    step();
    step();
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    total++; if (out_index !== '0) $display("FAIL rst_index got %0d want 0", out_index); else pass_cnt++;
    total++; if (out_value !== '0) $display("FAIL rst_value got %h want 0", out_value); else pass_cnt++;
    in_valid = 0;
    rst = 0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", in_ready); else pass_cnt++;
    step();
    total++; if (busy !== 1'b0) $display("FAIL rst_no_accept busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_directed(input lanes_t l, input string name);
    int ei, ev, lat;
    logic [SW-1:0] evb;
    model(l, ei, ev);
    evb = SW'(ev);
    total++; if (in_ready !== 1'b1) $display("FAIL %s_ready got %b want 1", name, in_ready); else pass_cnt++;
    run_one(l, lat);
    total++; if (lat !== 4) $display("FAIL %s_latency got %0d want 4", name, lat); else pass_cnt++;
    total++; if (out_index !== IW'(ei)) $display("FAIL %s_index got %0d want %0d", name, out_index, ei); else pass_cnt++;
    total++; if (out_value !== evb) $display("FAIL %s_value got %h want %h", name, out_value, evb); else pass_cnt++;
    consume();
    total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL %s_release got %b want 01", name, {out_valid, in_ready}); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    lanes_t l = '{-32768, 0, 0, 0, 32767};
    lanes_t other = '{100, 200, 300, 400, 500};
    int ei, ev, lat;
    logic [SW-1:0] evb;
    model(l, ei, ev);
    evb = SW'(ev);
    run_one(l, lat);
    total++; if (lat !== 4) $display("FAIL bp_latency got %0d want 4", lat); else pass_cnt++;
    in_valid = 1;
    result = pack(other);
    for (int c = 0; c < 10; c++) begin
      total++;
      if ({out_valid, in_ready, busy, out_index, out_value} !== {1'b1, 1'b0, 1'b1, IW'(ei), evb})
        $display("FAIL bp_hold cyc %0d got v%b r%b b%b %0d/%h want v1 r0 b1 %0d/%h",
                 c, out_valid, in_ready, busy, out_index, out_value, ei, evb);
      else pass_cnt++;
      step();
    end
    out_ready = 1;
    step();
    total++; if ({out_valid, in_ready, busy} !== 3'b010) $display("FAIL bp_consume got %b want 010", {out_valid, in_ready, busy}); else pass_cnt++;
    in_valid = 0;
    out_ready = 0;
    step();
    total++; if (busy !== 1'b0) $display("FAIL bp_no_accept busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_mid_scan_reset();
    lanes_t l = '{5, 6, 7, 8, 9};
    int seen = 0;
    result = pack(l);
    in_valid = 1;
    step();
    in_valid = 0;
    step();
    rst = 1;
    step();
    total++; if ({out_valid, in_ready, busy} !== 3'b000) $display("FAIL msr_during got %b want 000", {out_valid, in_ready, busy}); else pass_cnt++;
    rst = 0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL msr_ready got %b want 1", in_ready); else pass_cnt++;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) seen++;
      step();
    end
    total++; if (seen !== 0) $display("FAIL msr_out_valid got %0d cycles want 0", seen); else pass_cnt++;
    total++; if (out_index !== '0) $display("FAIL msr_index got %0d want 0", out_index); else pass_cnt++;
    total++; if (out_value !== '0) $display("FAIL msr_value got %h want 0", out_value); else pass_cnt++;
  endtask

  task automatic test_random();
    lanes_t l;
    int ei, ev, lat, hold;
    logic [SW-1:0] evb;
    for (int t = 0; t < 25; t++) begin
      rand_lanes(l, t[0]);
      model(l, ei, ev);
      evb = SW'(ev);
      total++; if (in_ready !== 1'b1) $display("FAIL rnd%0d_ready got %b want 1", t, in_ready); else pass_cnt++;
      run_one(l, lat);
      total++; if (lat !== 4) $display("FAIL rnd%0d_latency got %0d want 4", t, lat); else pass_cnt++;
      hold = int'($urandom_range(0, 3));
      for (int c = 0; c < hold; c++) step();
      total++;
      if ({out_valid, out_index, out_value} !== {1'b1, IW'(ei), evb})
        $display("FAIL rnd%0d_result got v%b %0d/%h want v1 %0d/%h", t, out_valid, out_index, out_value, ei, evb);
      else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_back_to_back();
    lanes_t a = '{1, 2, 3, 4, 5};
    lanes_t b = '{9, 0, 0, 0, 0};
    int ai, av, bi, bv;
    int acc = 0;
    int both = 0;
    int got_i[$];
    int got_v[$];
    bit fire_in, fire_out;
    model(a, ai, av);
    model(b, bi, bv);
    result = pack(a);
    in_valid = 1;
    out_ready = 1;
    for (int c = 0; c < 40 && got_i.size() < 2; c++) begin
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_in && fire_out) both++;
      if (fire_out) begin
        got_i.push_back(int'(out_index));
        got_v.push_back(int'($signed(out_value)));
      end
      step();
      if (fire_in) begin
        acc++;
        if (acc == 1) result = pack(b);
        else in_valid = 0;
      end
    end
    in_valid = 0;
    out_ready = 0;
    total++; if (acc !== 2) $display("FAIL b2b_accepts got %0d want 2", acc); else pass_cnt++;
    total++; if (both !== 0) $display("FAIL b2b_overlap got %0d want 0", both); else pass_cnt++;
    total++; if (got_i.size() !== 2) $display("FAIL b2b_results got %0d want 2", got_i.size()); else pass_cnt++;
    if (got_i.size() == 2) begin
      total++; if (got_i[0] !== ai || got_v[0] !== av) $display("FAIL b2b_first got %0d/%0d want %0d/%0d", got_i[0], got_v[0], ai, av); else pass_cnt++;
      total++; if (got_i[1] !== bi || got_v[1] !== bv) $display("FAIL b2b_second got %0d/%0d want %0d/%0d", got_i[1], got_v[1], bi, bv); else pass_cnt++;
    end
  endtask

  initial begin
    lanes_t l1 = '{10, -3, 42, 7, 42};
    lanes_t l2 = '{-5, -2, -9, -2, -100};
    rst = 1;
    in_valid = 0;
    out_ready = 0;
    result = '0;
    test_reset();
    test_directed(l1, "tie42");
    test_directed(l2, "neg");
    test_backpressure();
    test_mid_scan_reset();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/fc_argmax.md
FC_ARGMAX -- requirements
Module: fc_argmax

Interface
REQ-001 Parameter BITWIDTH, default 8, operand width of the upstream fully-connected stage; each score lane is 2*BITWIDTH bits.
REQ-002 Parameter OUTPUT_SIZE, default 5, number of score lanes (classes), minimum 1.
REQ-003 Derived IDX_W = max(1, clog2(OUTPUT_SIZE)), width of the class index.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  score vector on result is valid.
REQ-007 in_ready  output  1  block can accept a vector.
REQ-008 result  input  2*BITWIDTH*OUTPUT_SIZE  packed signed two's-complement scores; lane i at bits [(i+1)*2*BITWIDTH-1 -: 2*BITWIDTH].
REQ-009 out_valid  output  1  out_index/out_value hold a finished result.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_index  output  IDX_W  lane index of the maximum score.
REQ-012 out_value  output  2*BITWIDTH  signed maximum score.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states: IDLE, SCAN, DONE.
REQ-015 in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 Accept edge (IDLE, in_valid=1): register the full result vector; max <= lane 0; idx <= 0; ptr <= 1; next state SCAN, or DONE if OUTPUT_SIZE = 1.
REQ-017 Each SCAN edge compares captured lane ptr with max (signed); if strictly greater, max <= lane, idx <= ptr; ptr <= ptr+1.
REQ-018 After the edge that processes lane OUTPUT_SIZE-1, state goes to DONE; out_valid is therefore high OUTPUT_SIZE-1 cycles after the accept edge.
REQ-019 Ties: lowest lane index wins (strict greater-than only).
REQ-020 Input changes after the accept edge do not affect the result in progress.
REQ-021 DONE: out_index/out_value stable while out_ready = 0; edge with out_ready = 1 returns to IDLE.
REQ-022 No vector accepted in the cycle a result is consumed; the next accept occurs at the earliest one cycle later (IDLE).
REQ-023 Outside DONE, out_index and out_value hold their last values; they are meaningful only when out_valid = 1.
REQ-024 Comparison uses full 2*BITWIDTH signed range; no saturation, no overflow possible.

Reset
REQ-025 rst = 1 at a rising edge: state <= IDLE, out_index <= 0, out_value <= 0, ptr <= 0, captured vector cleared; effective in any state, including mid-SCAN and DONE.
REQ-026 While rst = 1: in_ready = 0, out_valid = 0, busy = 0; the first cycle after rst deasserts shows in_ready = 1.
REQ-027 A vector presented during reset is not accepted.

Configuration
REQ-028 Macro FC_ARGMAX_RELU_EN: when defined, each lane is clamped to max(lane, 0) at capture, so comparisons and out_value use clamped scores (out_value never negative).
REQ-029 When FC_ARGMAX_RELU_EN is undefined, raw signed scores are compared and reported; no clamp logic is present.

Verification (BITWIDTH=8, OUTPUT_SIZE=5)
REQ-030 Lanes {10,-3,42,7,42}, in_valid one cycle -> out_valid exactly 4 cycles after accept edge, out_index=2, out_value=42.
REQ-031 Lanes {-5,-2,-9,-2,-100} -> without macro out_index=1, out_value=-2 (0xFFFE); with FC_ARGMAX_RELU_EN out_index=0, out_value=0.
REQ-032 Lanes {-32768,0,0,0,32767}, out_ready held 0 for 10 cycles -> out_index=4, out_value=32767 stable throughout, in_ready=0, busy=1; out_ready=1 -> IDLE next cycle.
REQ-033 rst pulsed 2 cycles after accept (mid-SCAN) -> out_valid never rises for that vector, out_index=0, out_value=0, in_ready=1 the cycle after rst deasserts.
REQ-034 Back-to-back: in_valid held high with vectors A={1,2,3,4,5} then B={9,0,0,0,0} -> results 4/5 then 0/9, each accepted only in IDLE, no vector dropped or duplicated.
